// File: rtl/funnel_pkg.sv
// Shared types and helpers for the funnel sequencer.
// Config field positions, FSM states and the sel bit-reversal.
package funnel_pkg;

    localparam int CHUNK_W = 128;

    localparam int CFG_LAST_LO = 0;
    localparam int CFG_LAST_HI = 3;
    localparam int CFG_REV     = 4;

    typedef enum logic {
        IDLE,
        SEND
    } seqState;

    // Layer l of the funnel reads sel[l], so chunk idx needs its bits mirrored.
    function automatic logic [7:0] bitrev(
        input logic [7:0] idx,
        input int         steps
    );
        logic [7:0] r;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            if (l < steps) begin
                r[l] = idx[steps-1-l];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/funnel_seq.sv
// Wide-to-narrow funnel sequencer: holds one wide beat and
// walks the funnel select so chunks stream out one per ack.
module funnel_seq #(
    parameter int CHUNK_W = funnel_pkg::CHUNK_W,
    parameter int CHUNKS  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHUNKS*CHUNK_W-1:0] t_0_dat,
    input  logic                      t_0_req,
    output logic                      t_0_ack,
    input  logic [7:0]                t_cfg_dat,
    input  logic                      t_cfg_req,
    output logic                      t_cfg_ack,
    output logic [CHUNKS*CHUNK_W-1:0] hold_dat,
    output logic [7:0]                sel,
    output logic [7:0]                mode,
    output logic                      i_0_req,
    input  logic                      i_0_ack
);
    import funnel_pkg::*;

    localparam int STEPS = $clog2(CHUNKS);
    localparam int W     = CHUNKS * CHUNK_W;
    localparam logic [8:0] MAX_LAST = 9'(CHUNKS - 1);

    seqState          state;
    seqState          stateNext;
    logic [STEPS-1:0] idx;
    logic [STEPS-1:0] idxNext;
    logic [W-1:0]     holdNext;
    logic [7:0]       modeNext;

    logic [8:0]       lastWide;
    logic [STEPS-1:0] lastIdx;
    logic [STEPS-1:0] startIdx;
    logic [STEPS-1:0] endIdx;
    logic             rev;
    logic             atEnd;
    logic [8:0]       cfgLast;
    logic [7:0]       cfgClamped;

    assign rev      = mode[CFG_REV];
    assign lastWide = {5'b0, mode[CFG_LAST_HI:CFG_LAST_LO]};
    assign lastIdx  = lastWide[STEPS-1:0];
    assign startIdx = rev ? lastIdx : '0;
    assign endIdx   = rev ? '0 : lastIdx;
    assign atEnd    = (idx == endIdx);

    // Out-of-range last index saturates to the final chunk.
    assign cfgLast = {5'b0, t_cfg_dat[CFG_LAST_HI:CFG_LAST_LO]};
    always_comb begin
        cfgClamped = t_cfg_dat;
        if (cfgLast > MAX_LAST) begin
            cfgClamped[CFG_LAST_HI:CFG_LAST_LO] = MAX_LAST[3:0];
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        holdNext  = hold_dat;
        modeNext  = mode;
        t_0_ack   = 1'b0;
        t_cfg_ack = 1'b0;
        unique case (state)
            IDLE: begin
                t_cfg_ack = 1'b1;
                t_0_ack   = !t_cfg_req;
                if (t_cfg_req) begin
                    modeNext = cfgClamped;
                end else if (t_0_req) begin
                    holdNext  = t_0_dat;
                    idxNext   = startIdx;
                    stateNext = SEND;
                end
            end
            SEND: begin
                t_0_ack = i_0_ack & atEnd & !t_cfg_req;
                if (i_0_ack) begin
                    if (!atEnd) begin
                        idxNext = rev ? idx - STEPS'(1) : idx + STEPS'(1);
                    end else if (t_0_req && t_0_ack) begin
                        holdNext = t_0_dat;
                        idxNext  = startIdx;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            hold_dat <= '0;
            mode     <= 8'(CHUNKS - 1);
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            hold_dat <= holdNext;
            mode     <= modeNext;
        end
    end

    assign i_0_req = (state == SEND);
    assign sel     = i_0_req ? bitrev(8'(idx), STEPS) : 8'h00;

endmodule

// File: tb/tb_funnel_seq.sv
// Scoreboard bench for funnel_seq: expected chunks queued on beat accept,
// popped and compared by a monitor on every narrow transfer.
module tb_funnel_seq;

    localparam int CW     = 128;
    localparam int CHUNKS = 4;
    localparam int STEPS  = 2;
    localparam int W      = CW * CHUNKS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  t_0_dat = '0;
    logic          t_0_req = 1'b0;
    logic          t_0_ack;
    logic [7:0]    t_cfg_dat = '0;
    logic          t_cfg_req = 1'b0;
    logic          t_cfg_ack;
    logic [W-1:0]  hold_dat;
    logic [7:0]    sel;
    logic [7:0]    mode;
    logic          i_0_req;
    logic          i_0_ack = 1'b1;

    funnel_seq #(.CHUNK_W(CW), .CHUNKS(CHUNKS)) dut (
        .clk(clk), .reset_n(reset_n),
        .t_0_dat(t_0_dat), .t_0_req(t_0_req), .t_0_ack(t_0_ack),
        .t_cfg_dat(t_cfg_dat), .t_cfg_req(t_cfg_req), .t_cfg_ack(t_cfg_ack),
        .hold_dat(hold_dat), .sel(sel), .mode(mode),
        .i_0_req(i_0_req), .i_0_ack(i_0_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] dat;
        logic [7:0]    sel;
    } expT;

    expT           q[$];
    int            checks = 0;
    int            failures = 0;
    logic [7:0]    mMode = 8'(CHUNKS - 1);
    bit            ackRand = 0;
    bit            holdPending = 0;
    logic [7:0]    pSel;
    logic [W-1:0]  pHold;

    function automatic void chk(string n, logic [CW-1:0] act, logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", n, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] mirror(int k);
        logic [7:0] r = '0;
        for (int l = 0; l < STEPS; l++) r[l] = k[STEPS-1-l];
        return r;
    endfunction

    function automatic int chunkOf(logic [7:0] s);
        int k = 0;
        for (int l = 0; l < STEPS; l++) k[STEPS-1-l] = s[l];
        return k;
    endfunction

    // Monitor: model outputs from outstanding-chunk count, score transfers.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            holdPending = 0;
            mMode = 8'(CHUNKS - 1);
            chk("rst_i_0_req", CW'(i_0_req), CW'(0));
            chk("rst_sel", CW'(sel), CW'(0));
            chk("rst_hold", CW'(hold_dat == '0), CW'(1));
            chk("rst_mode", CW'(mode), CW'(CHUNKS - 1));
        end else begin
            chk("i_0_req", CW'(i_0_req), CW'(q.size() != 0));
            chk("t_cfg_ack", CW'(t_cfg_ack), CW'(q.size() == 0));
            chk("t_0_ack", CW'(t_0_ack),
                CW'(!t_cfg_req && (q.size() == 0 || (q.size() == 1 && i_0_ack))));
            chk("mode", CW'(mode), CW'(mMode));
            if (holdPending) begin
                chk("hold_sel", CW'(sel), CW'(pSel));
                chk("hold_dat", CW'(hold_dat == pHold), CW'(1));
            end
            holdPending = i_0_req && !i_0_ack;
            pSel = sel;
            pHold = hold_dat;
            if (i_0_req && i_0_ack && q.size() > 0) begin
                expT e;
                e = q.pop_front();
                chk("sel", CW'(sel), CW'(e.sel));
                chk("i_0_dat", hold_dat[chunkOf(sel)*CW +: CW], e.dat);
            end
            if (t_0_req && t_0_ack) begin
                int last;
                last = int'(mMode[3:0]);
                for (int j = 0; j <= last; j++) begin
                    expT e;
                    int k;
                    k = mMode[4] ? last - j : j;
                    e.dat = t_0_dat[k*CW +: CW];
                    e.sel = mirror(k);
                    q.push_back(e);
                end
            end
            if (t_cfg_req && t_cfg_ack) begin
                mMode = t_cfg_dat;
                if (int'(t_cfg_dat[3:0]) > CHUNKS - 1) mMode[3:0] = 4'(CHUNKS - 1);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_0_ack = ackRand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic sendBeat(input logic [W-1:0] d);
        bit ok = 0;
        int n = 0;
        t_0_dat = d;
        t_0_req = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = t_0_ack;
            @(posedge clk);
            #1;
            n++;
        end
        t_0_req = 1'b0;
        if (!ok) chk("beat_timeout", CW'(0), CW'(1));
    endtask

    task automatic sendCfg(input logic [7:0] c);
        bit ok = 0;
        int n = 0;
        t_cfg_dat = c;
        t_cfg_req = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = t_cfg_ack;
            @(posedge clk);
            #1;
            n++;
        end
        t_cfg_req = 1'b0;
        if (!ok) chk("cfg_timeout", CW'(0), CW'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drained", CW'(q.size()), CW'(0));
    endtask

    function automatic logic [W-1:0] patBeat();
        logic [W-1:0] b;
        for (int k = 0; k < CHUNKS; k++) b[k*CW +: CW] = CW'(32'hA0 + k);
        return b;
    endfunction

    function automatic logic [W-1:0] rndBeat();
        logic [W-1:0] b;
        for (int i = 0; i < W / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        sendBeat(patBeat());
        drain();

        sendCfg(8'h13);
        sendBeat(patBeat());
        drain();

        sendCfg(8'h01);
        sendBeat(rndBeat());
        sendBeat(rndBeat());
        drain();

        ackRand = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) sendCfg(8'($urandom));
            sendBeat(rndBeat());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        drain();
        ackRand = 0;
        @(posedge clk);
        #1;

        t_cfg_dat = 8'h0F;
        t_cfg_req = 1'b1;
        t_0_dat = patBeat();
        t_0_req = 1'b1;
        @(negedge clk);
        chk("t5_cfg_first", CW'({t_cfg_ack, t_0_ack}), CW'(2'b10));
        @(posedge clk);
        #1;
        t_cfg_req = 1'b0;
        chk("t5_mode_clamp", CW'(mode), CW'(8'h03));
        sendBeat(patBeat());
        drain();

        sendCfg(8'h13);
        sendBeat(patBeat());
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("t6_async_drop", CW'(i_0_req), CW'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk("t6_mode_reset", CW'(mode), CW'(8'h03));
        @(posedge clk);
        #1;
        sendBeat(patBeat());
        @(negedge clk);
        chk("t6_first_chunk", hold_dat[chunkOf(sel)*CW +: CW], CW'(32'hA0));
        @(posedge clk);
        #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
